// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, ALU control and datapath.
// Opcodes, 4-bit sequencer states and the mux/ALU select encodings.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    typedef enum logic [3:0] {
        S_RESET0    = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        ASB_RT      = 2'b00,
        ASB_FOUR    = 2'b01,
        ASB_IMM     = 2'b10,
        ASB_IMM_SL2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,
        PCS_ALUOUT = 2'b01,
        PCS_JUMP   = 2'b10
    } pc_src_e;

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_J, OP_BEQ, OP_BNE: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure combinational decode of sequencer state (plus op_q, zero, mem_ready) to datapath controls.
// RESET0 and unused codes drive every control low.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e      state,
    input  logic [5:0]  op_q,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        illegal_op
);

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_RT;
        alu_op     = ALU_ADD;
        pc_source  = PCS_ALU;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ASB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = ASB_IMM_SL2;
                illegal_op = ~is_known_op(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = PCS_ALUOUT;
                pc_write  = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);
            end
            S_JUMP: begin
                pc_source = PCS_JUMP;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer: holds state/op_q, stalls FETCH/MEM_RD/MEM_WR on mem_ready, decodes via outdec.
// Optional retire counter under `ifdef MIPS_CTRL_PERF_CNT_EN.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ir_write,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              reg_dst,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic [1:0]        pc_source,
    output logic              illegal_op,
`ifdef MIPS_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0]  retire_count,
`endif
    output logic [3:0]        state_o
);

    state_e     state_q;
    logic [5:0] op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET0;
            op_q    <= '0;
        end else begin
            case (state_q)
                S_RESET0: state_q <= S_FETCH;
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LW, OP_SW:    state_q <= S_MEM_ADDR;
                        OP_R:            state_q <= S_R_EXEC;
                        OP_ADDI:         state_q <= S_ADDI_EXEC;
                        OP_BEQ, OP_BNE:  state_q <= S_BRANCH;
                        OP_J:            state_q <= S_JUMP;
                        default:         state_q <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  state_q <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:    if (mem_ready) state_q <= S_MEM_WB;
                S_MEM_WR:    if (mem_ready) state_q <= S_FETCH;
                S_R_EXEC:    state_q <= S_R_WB;
                S_ADDI_EXEC: state_q <= S_ADDI_WB;
                default:     state_q <= S_FETCH;
            endcase
        end
    end

    assign state_o = state_q;

`ifdef MIPS_CTRL_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] retire_count_q;

    // An illegal opcode leaves DECODE straight to FETCH and is deliberately not counted.
    always_comb begin
        case (state_q)
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WR:                                       retire = mem_ready;
            default:                                        retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retire_count_q <= '0;
        else if (retire) retire_count_q <= retire_count_q + 1'b1;
    end

    assign retire_count = retire_count_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 0);
`endif

    mips_ctrl_outdec u_outdec (
        .state      (state_q),
        .op_q       (op_q),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (illegal_op)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level model predicts state path and control tallies.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zero, mem_ready;
    logic        pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic        reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state_o;
`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [31:0] retire_count;
    int          exp_retired;
`endif

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
`ifdef MIPS_CTRL_PERF_CNT_EN
        .retire_count(retire_count),
`endif
        .state_o(state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model outputs for one instruction
    int   exp_path[$];
    bit   exp_rdy[$];
    int   e_pcw, e_regw, e_mrd, e_mwr, e_ill, e_dst, e_m2r, e_brsrc, e_legal;
    // Observations for one instruction
    int   obs_path[$];
    int   o_irw, o_pcw, o_regw, o_mrd, o_mwr, o_ill, o_dst, o_m2r, o_brsrc, o_conflict;

    function automatic logic [15:0] all_outs();
        return {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    endfunction

    task automatic model_instr(input logic [5:0] op, input bit z, input int wf, input int wm);
        bit taken;
        exp_path.delete(); exp_rdy.delete();
        repeat (wf) begin exp_path.push_back(1); exp_rdy.push_back(1'b0); end
        exp_path.push_back(1); exp_rdy.push_back(1'b1);
        exp_path.push_back(2); exp_rdy.push_back(1'($urandom_range(0, 1)));
        e_legal = 1;
        case (op)
            6'b100011: begin
                exp_path.push_back(3); exp_rdy.push_back(1'($urandom_range(0, 1)));
                repeat (wm) begin exp_path.push_back(4); exp_rdy.push_back(1'b0); end
                exp_path.push_back(4); exp_rdy.push_back(1'b1);
                exp_path.push_back(5); exp_rdy.push_back(1'($urandom_range(0, 1)));
            end
            6'b101011: begin
                exp_path.push_back(3); exp_rdy.push_back(1'($urandom_range(0, 1)));
                repeat (wm) begin exp_path.push_back(6); exp_rdy.push_back(1'b0); end
                exp_path.push_back(6); exp_rdy.push_back(1'b1);
            end
            6'b000000: begin exp_path.push_back(7); exp_path.push_back(8);
                             exp_rdy.push_back(1'b1); exp_rdy.push_back(1'b0); end
            6'b001000: begin exp_path.push_back(11); exp_path.push_back(12);
                             exp_rdy.push_back(1'b0); exp_rdy.push_back(1'b1); end
            6'b000100, 6'b000101: begin exp_path.push_back(9); exp_rdy.push_back(1'($urandom_range(0, 1))); end
            6'b000010: begin exp_path.push_back(10); exp_rdy.push_back(1'($urandom_range(0, 1))); end
            default: e_legal = 0;
        endcase
        taken   = (op == 6'b000010) || (op == 6'b000100 && z) || (op == 6'b000101 && !z);
        e_pcw   = 1 + int'(taken);
        e_regw  = (op == 6'b000000 || op == 6'b001000 || op == 6'b100011) ? 1 : 0;
        e_mrd   = wf + 1 + ((op == 6'b100011) ? wm + 1 : 0);
        e_mwr   = (op == 6'b101011) ? wm + 1 : 0;
        e_ill   = 1 - e_legal;
        e_dst   = (op == 6'b000000) ? 1 : 0;
        e_m2r   = (op == 6'b100011) ? 1 : 0;
        e_brsrc = (op == 6'b000010) ? 2 : (taken ? 1 : 0);
    endtask

    // Drives exactly the model's cycle count, so a diverging DUT cannot stall the bench.
    task automatic drive_instr(input logic [5:0] op, input bit z, input int wf, input int wm);
        model_instr(op, z, wf, wm);
        obs_path.delete();
        o_irw = 0; o_pcw = 0; o_regw = 0; o_mrd = 0; o_mwr = 0; o_ill = 0;
        o_dst = 0; o_m2r = 0; o_brsrc = 0; o_conflict = 0;
        for (int i = 0; i < exp_path.size(); i++) begin
            @(negedge clk);
            opcode = op; zero = z; mem_ready = exp_rdy[i];
            #1;
            obs_path.push_back(int'(state_o));
            o_irw  += int'(ir_write);  o_pcw += int'(pc_write); o_regw += int'(reg_write);
            o_mrd  += int'(mem_read);  o_mwr += int'(mem_write); o_ill += int'(illegal_op);
            if (reg_write) begin o_dst = int'(reg_dst); o_m2r = int'(mem_to_reg); end
            if (pc_write && !ir_write) o_brsrc = int'(pc_source);
            if ((mem_read && mem_write) || (reg_write && pc_write)) o_conflict++;
        end
    endtask

    function automatic int path_errors();
        int e = (obs_path.size() == exp_path.size()) ? 0 : 1;
        for (int i = 0; i < obs_path.size() && i < exp_path.size(); i++)
            if (obs_path[i] != exp_path[i]) e++;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (state_o !== 4'd0 || all_outs() !== 16'h0) begin
            n_fail++; $display("FAIL reset_hold: state=%0d outs=%h required state=0 outs=0", state_o, all_outs());
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++;
        if (state_o !== 4'd0 || all_outs() !== 16'h0) begin
            n_fail++; $display("FAIL reset_release: state=%0d outs=%h required state=0 outs=0", state_o, all_outs());
        end
        @(posedge clk); #1;
        n_checks++;
        if (state_o !== 4'd1 || mem_read !== 1'b1 || ir_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_to_fetch: state=%0d mem_read=%b ir_write=%b required 1/1/0", state_o, mem_read, ir_write);
        end
`ifdef MIPS_CTRL_PERF_CNT_EN
        exp_retired = 0;
        n_checks++;
        if (retire_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d required 0", retire_count);
        end
`endif
    endtask

    task automatic test_add();
        drive_instr(6'b000000, 1'b0, 0, 0);
`ifdef MIPS_CTRL_PERF_CNT_EN
        exp_retired++;
`endif
        n_checks++;
        if (path_errors() != 0 || obs_path.size() != 4) begin
            n_fail++; $display("FAIL add_path: %0d state errors over %0d cycles, required 0 over 4", path_errors(), obs_path.size());
        end
        n_checks++;
        if (o_regw != 1 || o_dst != 1 || o_m2r != 0) begin
            n_fail++; $display("FAIL add_wb: reg_write=%0d reg_dst=%0d mem_to_reg=%0d required 1/1/0", o_regw, o_dst, o_m2r);
        end
    endtask

    task automatic test_lw_wait();
        drive_instr(6'b100011, 1'b0, 3, 3);
`ifdef MIPS_CTRL_PERF_CNT_EN
        exp_retired++;
`endif
        n_checks++;
        if (path_errors() != 0 || obs_path.size() != 11) begin
            n_fail++; $display("FAIL lw_path: %0d state errors over %0d cycles, required 0 over 11", path_errors(), obs_path.size());
        end
        n_checks++;
        if (o_irw != 1 || o_pcw != 1) begin
            n_fail++; $display("FAIL lw_fetch_pulse: ir_write=%0d pc_write=%0d required 1/1", o_irw, o_pcw);
        end
        n_checks++;
        if (o_regw != 1 || o_m2r != 1 || o_dst != 0 || o_mrd != 8) begin
            n_fail++; $display("FAIL lw_wb: reg_write=%0d mem_to_reg=%0d reg_dst=%0d mem_read_cycles=%0d required 1/1/0/8",
                               o_regw, o_m2r, o_dst, o_mrd);
        end
    endtask

    task automatic test_branch();
        drive_instr(6'b000100, 1'b1, 0, 0);
`ifdef MIPS_CTRL_PERF_CNT_EN
        exp_retired++;
`endif
        n_checks++;
        if (path_errors() != 0 || o_pcw != 2 || o_brsrc != 1) begin
            n_fail++; $display("FAIL beq_taken: path_err=%0d pc_write=%0d pc_source=%0d required 0/2/1", path_errors(), o_pcw, o_brsrc);
        end
        drive_instr(6'b000101, 1'b1, 0, 0);
`ifdef MIPS_CTRL_PERF_CNT_EN
        exp_retired++;
`endif
        n_checks++;
        if (path_errors() != 0 || o_pcw != 1) begin
            n_fail++; $display("FAIL bne_not_taken: path_err=%0d pc_write=%0d required 0/1", path_errors(), o_pcw);
        end
    endtask

    task automatic test_illegal();
        drive_instr(6'b111111, 1'b0, 0, 0);
        n_checks++;
        if (path_errors() != 0 || o_ill != 1) begin
            n_fail++; $display("FAIL illegal_pulse: path_err=%0d illegal_op=%0d required 0/1", path_errors(), o_ill);
        end
        n_checks++;
        if (o_regw != 0 || o_mwr != 0 || o_pcw != 1) begin
            n_fail++; $display("FAIL illegal_no_write: reg_write=%0d mem_write=%0d pc_write=%0d required 0/0/1", o_regw, o_mwr, o_pcw);
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_checks++;
        if (state_o !== 4'd1) begin
            n_fail++; $display("FAIL illegal_next: state=%0d required 1", state_o);
        end
    endtask

    task automatic test_random_stream();
        logic [5:0] legal_ops [7];
        logic [5:0] op;
        bit         z;
        int         wf, wm;
        legal_ops = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000010, 6'b000100, 6'b000101};
        // test_illegal left the DUT one cycle into FETCH with mem_ready low: finish that fetch first.
        drive_instr(6'b000010, 1'b0, 0, 0);
`ifdef MIPS_CTRL_PERF_CNT_EN
        exp_retired++;
`endif
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63));
                while (op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000010, 6'b000100, 6'b000101});
            end else begin
                op = legal_ops[$urandom_range(0, 6)];
            end
            z  = 1'($urandom_range(0, 1));
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            drive_instr(op, z, wf, wm);
`ifdef MIPS_CTRL_PERF_CNT_EN
            exp_retired += e_legal;
`endif
            n_checks++;
            if (path_errors() != 0) begin
                n_fail++; $display("FAIL rand_path op=%b: %0d state errors required 0", op, path_errors());
            end
            n_checks++;
            if (o_irw != 1 || o_pcw != e_pcw || o_brsrc != e_brsrc) begin
                n_fail++; $display("FAIL rand_pc op=%b z=%b: ir_write=%0d pc_write=%0d pc_source=%0d required 1/%0d/%0d",
                                   op, z, o_irw, o_pcw, o_brsrc, e_pcw, e_brsrc);
            end
            n_checks++;
            if (o_regw != e_regw || o_dst != e_dst || o_m2r != e_m2r || o_ill != e_ill) begin
                n_fail++; $display("FAIL rand_wb op=%b: reg_write=%0d reg_dst=%0d mem_to_reg=%0d illegal=%0d required %0d/%0d/%0d/%0d",
                                   op, o_regw, o_dst, o_m2r, o_ill, e_regw, e_dst, e_m2r, e_ill);
            end
            n_checks++;
            if (o_mrd != e_mrd || o_mwr != e_mwr || o_conflict != 0) begin
                n_fail++; $display("FAIL rand_mem op=%b: mem_read=%0d mem_write=%0d conflicts=%0d required %0d/%0d/0",
                                   op, o_mrd, o_mwr, o_conflict, e_mrd, e_mwr);
            end
        end
`ifdef MIPS_CTRL_PERF_CNT_EN
        @(posedge clk); #1;
        n_checks++;
        if (retire_count !== 32'(exp_retired)) begin
            n_fail++; $display("FAIL rand_retire: got %0d required %0d", retire_count, exp_retired);
        end
`endif
    endtask

    task automatic test_async_reset();
        int path[4] = '{1, 2, 3, 6};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode = 6'b101011; zero = 1'b0; mem_ready = (i == 0);
        end
        #1;
        n_checks++;
        if (state_o !== 4'(path[3]) || mem_write !== 1'b1) begin
            n_fail++; $display("FAIL sw_wait: state=%0d mem_write=%b required 6/1", state_o, mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || state_o !== 4'd0) begin
            n_fail++; $display("FAIL async_abort: mem_write=%b mem_read=%b state=%0d required 0/0/0", mem_write, mem_read, state_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk);
`ifdef MIPS_CTRL_PERF_CNT_EN
        exp_retired = 0;
`endif
    endtask

`ifdef MIPS_CTRL_PERF_CNT_EN
    task automatic test_perf();
        drive_instr(6'b001000, 1'b0, 1, 0);
        drive_instr(6'b111111, 1'b0, 0, 0);
        drive_instr(6'b101011, 1'b0, 0, 2);
        drive_instr(6'b000101, 1'b0, 0, 0);
        @(posedge clk); #1;
        n_checks++;
        if (retire_count !== 32'd3) begin
            n_fail++; $display("FAIL perf_three: got %0d required 3", retire_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_random_stream();
        test_async_reset();
`ifdef MIPS_CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
